nmi_rr_arbiter: RTL

- Round-robin arbiter sharing one downstream NMI slave port between NUM_REQ NMI requesters (user core, DMA, debug master).
- Sits between the user-core wrappers and the memory/peripheral crossbar.
- One outstanding transaction at a time.
- Command is registered at grant, so the downstream port is glitch-free and independent of requester behaviour after grant.

---
 rtl/nmi_rr_arbiter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/nmi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nmi_rr_arbiter
//
// Round-robin arbiter that shares one downstream NMI slave port between
// NUM_REQ NMI requesters (user core, DMA, debug master). Only one transaction
// is outstanding at a time. The winning command is captured into registers at
// grant time, so the downstream port stays stable no matter what the requester
// does after it has been granted.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  watchdog limit in BUSY cycles (timeout build only)
//
// Optional feature
//   NMI_ARB_TIMEOUT_EN  when defined, a watchdog completes a stalled
//                       transaction after TIMEOUT_CYCLES BUSY cycles. It
//                       returns 32'hDEAD_BEEF and sets the sticky
//                       timeout_err_o flag. When undefined, BUSY waits
//                       indefinitely and timeout_err_o is tied to 0.
//
// Ports
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   s_valid_i      per-requester request valid
//   s_addr_i       per-requester address, requester k in [32k+31:32k]
//   s_wdata_i      per-requester write data
//   s_wstrb_i      per-requester byte strobes (0 = read)
//   s_ready_o      one-cycle completion pulse to the granted requester
//   s_rdata_o      read data, slice of the granted requester, valid with ready
//   m_valid_o      downstream request valid
//   m_addr_o       downstream address
//   m_wdata_o      downstream write data
//   m_wstrb_o      downstream byte strobes
//   m_ready_i      downstream completion
//   m_rdata_i      downstream read data
//   grant_o        one-hot current grant, 0 when idle
//   timeout_err_o  sticky watchdog error flag
// -----------------------------------------------------------------------------
module nmi_rr_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_REQ-1:0]    s_valid_i,
    input  logic [NUM_REQ*32-1:0] s_addr_i,
    input  logic [NUM_REQ*32-1:0] s_wdata_i,
    input  logic [NUM_REQ*4-1:0]  s_wstrb_i,
    output logic [NUM_REQ-1:0]    s_ready_o,
    output logic [NUM_REQ*32-1:0] s_rdata_o,
    output logic                  m_valid_o,
    output logic [31:0]           m_addr_o,
    output logic [31:0]           m_wdata_o,
    output logic [3:0]            m_wstrb_o,
    input  logic                  m_ready_i,
    input  logic [31:0]           m_rdata_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic                  timeout_err_o
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    // One extra bit so pointer + offset never overflows before the wrap.
    localparam int CAND_W = PTR_W + 1;
    // Pointer resets to the last requester so requester 0 wins first.
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("nmi_rr_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_gidx;
    logic [NUM_REQ-1:0]   r_grant;
    logic                 r_m_valid;
    logic [31:0]          r_m_addr;
    logic [31:0]          r_m_wdata;
    logic [3:0]           r_m_wstrb;

    logic                 w_any;
    logic                 w_sel_found;
    logic [PTR_W-1:0]     w_sel_idx;
    logic [CAND_W-1:0]    w_cand;
    logic                 w_done;
    logic [31:0]          w_rdata;
    logic [NUM_REQ-1:0]   w_s_ready;
    logic [NUM_REQ*32-1:0] w_s_rdata;

    assign w_any = |s_valid_i;

    // Round-robin search: first set valid bit starting at pointer+1, wrapping
    // modulo NUM_REQ (which need not be a power of two).
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_cand      = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_cand = CAND_W'(r_ptr) + CAND_W'(i);
            if (w_cand >= CAND_W'(NUM_REQ)) begin
                w_cand = w_cand - CAND_W'(NUM_REQ);
            end
            if (!w_sel_found && s_valid_i[w_cand[PTR_W-1:0]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_cand[PTR_W-1:0];
            end
        end
    end

`ifdef NMI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout_err;
    logic             w_timeout;

    // A real completion in the last watchdog cycle takes priority.
    assign w_timeout     = (r_state == ST_BUSY) && !m_ready_i && (r_cnt == CNT_LAST);
    assign w_done        = (r_state == ST_BUSY) && (m_ready_i || w_timeout);
    assign w_rdata       = m_ready_i ? m_rdata_i : 32'hDEAD_BEEF;
    assign timeout_err_o = r_timeout_err;
`else
    assign w_done        = (r_state == ST_BUSY) && m_ready_i;
    assign w_rdata       = m_rdata_i;
    assign timeout_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PTR_RST;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_m_valid <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_m_wstrb <= '0;
`ifdef NMI_ARB_TIMEOUT_EN
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef NMI_ARB_TIMEOUT_EN
                    // Held at zero while idle, so every BUSY entry starts at 0.
                    r_cnt <= '0;
`endif
                    if (w_any) begin
                        r_state   <= ST_BUSY;
                        r_gidx    <= w_sel_idx;
                        r_grant   <= NUM_REQ'(1) << w_sel_idx;
                        r_m_valid <= 1'b1;
                        r_m_addr  <= s_addr_i[{w_sel_idx, 5'b00000} +: 32];
                        r_m_wdata <= s_wdata_i[{w_sel_idx, 5'b00000} +: 32];
                        r_m_wstrb <= s_wstrb_i[{w_sel_idx, 2'b00} +: 4];
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state   <= ST_IDLE;
                        r_ptr     <= r_gidx;
                        r_grant   <= '0;
                        r_m_valid <= 1'b0;
                        r_m_addr  <= '0;
                        r_m_wdata <= '0;
                        r_m_wstrb <= '0;
                    end
`ifdef NMI_ARB_TIMEOUT_EN
                    else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_timeout) begin
                        r_timeout_err <= 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Completion is forwarded combinationally in the same cycle as m_ready_i.
    always_comb begin
        w_s_ready = '0;
        w_s_rdata = '0;
        if (w_done) begin
            w_s_ready = r_grant;
            w_s_rdata[{r_gidx, 5'b00000} +: 32] = w_rdata;
        end
    end

    assign s_ready_o = w_s_ready;
    assign s_rdata_o = w_s_rdata;
    assign m_valid_o = r_m_valid;
    assign m_addr_o  = r_m_addr;
    assign m_wdata_o = r_m_wdata;
    assign m_wstrb_o = r_m_wstrb;
    assign grant_o   = r_grant;

endmodule
